// File: rtl/matrix_bram_pkg.sv
// rtl/matrix_bram_pkg.sv - arbiter state type and default matrix BRAM widths
package matrix_bram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int MATRIX_ADDR_WIDTH = 14;
  localparam int MATRIX_DATA_WIDTH = 32;

endpackage

// File: rtl/matrix_bram_arbiter_rr_picker.sv
// rtl/matrix_bram_arbiter_rr_picker.sv - combinational round-robin winner search
// Search begins one past i_last and wraps, so the previous owner is considered last.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = int'(i_last) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_valid && i_req[IDX_W'(w_pos)]) begin
        o_valid                  = 1'b1;
        o_idx                    = IDX_W'(w_pos);
        o_onehot[IDX_W'(w_pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// rtl/matrix_bram_arbiter.sv - session-based round-robin owner of the matrix BRAM port
// Optional session watchdog and revoke mask enabled by defining ARB_TIMEOUT_EN.
module matrix_bram_arbiter
  import matrix_bram_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH
`ifdef ARB_TIMEOUT_EN
  , parameter int HOLD_TIMEOUT = 4096
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_REQ-1:0]            m_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] m_din,
  output logic [DATA_WIDTH-1:0]         m_dout,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_we,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_last_owner, w_last_owner_nxt;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic               w_owner_req;
  logic               w_revoke;

  // r_last_owner doubles as the current owner index while in GRANT
  assign w_owner_req = req[r_last_owner];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_TIMEOUT);

  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_mask;
  logic               r_timeout_err;
  logic               w_new_grant;

  assign w_eligible  = req & ~r_mask;
  assign w_revoke    = (r_state == ARB_GRANT) && w_owner_req &&
                       (r_cnt == CNT_W'(HOLD_TIMEOUT - 1));
  assign w_new_grant = (r_state != ARB_GRANT) && w_win_valid;
  assign timeout_err = r_timeout_err;

  // A revoked requester stays masked until it is seen with req low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_mask        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_new_grant) r_cnt <= '0;
      else if (r_state == ARB_GRANT) r_cnt <= r_cnt + 1'b1;
      r_mask        <= (r_mask & req) | (w_revoke ? r_grant : '0);
      r_timeout_err <= w_revoke;
    end
  end
`else
  assign w_eligible  = req;
  assign w_revoke    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req    (w_eligible),
    .i_last   (r_last_owner),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_owner_nxt = r_last_owner;
    unique case (r_state)
      ARB_IDLE, ARB_RELEASE: begin
        if (w_win_valid) begin
          w_grant_nxt      = w_win_onehot;
          w_last_owner_nxt = w_win_idx;
          w_state_nxt      = ARB_GRANT;
        end else begin
          w_grant_nxt = '0;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (!w_owner_req || w_revoke) begin
          w_grant_nxt = '0;
          w_state_nxt = ARB_RELEASE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // Port mux keyed off the registered one-hot grant; RELEASE and IDLE drive zeros
  always_comb begin
    bram_addr = '0;
    bram_we   = 1'b0;
    bram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        bram_addr = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bram_we   = m_we[i];
        bram_din  = m_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant  = r_grant;
  assign busy   = |r_grant;
  assign m_dout = bram_dout;

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// tb/tb_matrix_bram_arbiter.sv - directed vector bench for matrix_bram_arbiter (ARB_TIMEOUT_EN adds the revoke sequence)
module tb_matrix_bram_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    m_we = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [AW-1:0]   a [N];
  logic [DW-1:0]   d [N];
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_din;
  logic [DW-1:0]   m_dout;
  logic [AW-1:0]   bram_addr;
  logic            bram_we;
  logic [DW-1:0]   bram_din;
  logic [DW-1:0]   bram_dout;
  logic            timeout_err;
  logic [DW-1:0]   mem [0:255];

  assign m_addr = {a[2], a[1], a[0]};
  assign m_din  = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  // BRAM model: 1-cycle read, reloaded with 0x1000+addr while reset is held
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000 + k;
      bram_dout <= '0;
    end else begin
      if (bram_we) mem[bram_addr[7:0]] <= bram_din;
      bram_dout <= mem[bram_addr[7:0]];
    end
  end

  matrix_bram_arbiter #(
    .NUM_REQ      (N),
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW)
`ifdef ARB_TIMEOUT_EN
    , .HOLD_TIMEOUT (16)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .busy        (busy),
    .m_addr      (m_addr),
    .m_we        (m_we),
    .m_din       (m_din),
    .m_dout      (m_dout),
    .bram_addr   (bram_addr),
    .bram_we     (bram_we),
    .bram_din    (bram_din),
    .bram_dout   (bram_dout),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  we;
    logic [N-1:0]  gnt;
    logic          bwe;
    logic [AW-1:0] baddr;
  } vec_t;

  vec_t tbl [32];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] g,
                     input logic bw, input int ba);
    tbl[n_vec] = '{r, w, g, bw, AW'(ba)};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    m_we  = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_din(input logic [N-1:0] g);
    exp_din = '0;
    for (int i = 0; i < N; i++) if (g[i]) exp_din = 32'hA0 + i;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // Reset state, with requests asserted to show reset dominates
    req  = 3'b111;
    m_we = 3'b111;
    step();
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst bram_addr", 64'(bram_addr), 64'd0);
    chk("rst bram_we", 64'(bram_we), 64'd0);
    chk("rst bram_din", 64'(bram_din), 64'd0);
    chk("rst timeout_err", 64'(timeout_err), 64'd0);

    // Rotation with all three requesting: 4-cycle sessions, 2-cycle req gaps
    add(3'b111, 3'b111, 3'b000, 1'b0, 0);
    add(3'b111, 3'b111, 3'b001, 1'b1, 40);
    add(3'b111, 3'b111, 3'b001, 1'b1, 40);
    add(3'b111, 3'b111, 3'b001, 1'b1, 40);
    add(3'b110, 3'b111, 3'b001, 1'b1, 40);
    add(3'b110, 3'b111, 3'b000, 1'b0, 0);
    add(3'b111, 3'b111, 3'b010, 1'b1, 41);
    add(3'b111, 3'b111, 3'b010, 1'b1, 41);
    add(3'b111, 3'b111, 3'b010, 1'b1, 41);
    add(3'b101, 3'b111, 3'b010, 1'b1, 41);
    add(3'b101, 3'b111, 3'b000, 1'b0, 0);
    add(3'b111, 3'b111, 3'b100, 1'b1, 42);
    add(3'b111, 3'b111, 3'b100, 1'b1, 42);
    add(3'b111, 3'b111, 3'b100, 1'b1, 42);
    add(3'b011, 3'b111, 3'b100, 1'b1, 42);
    add(3'b011, 3'b111, 3'b000, 1'b0, 0);
    add(3'b111, 3'b111, 3'b001, 1'b1, 40);
    add(3'b111, 3'b000, 3'b001, 1'b0, 40);
    add(3'b000, 3'b000, 3'b001, 1'b0, 40);
    add(3'b000, 3'b000, 3'b000, 1'b0, 0);
    add(3'b000, 3'b000, 3'b000, 1'b0, 0);

    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(40 + i);
      d[i] = 32'hA0 + i;
    end
    for (int r = 0; r < n_vec; r++) begin
      req  = tbl[r].req;
      m_we = tbl[r].we;
      #2;
      chk($sformatf("row%0d grant", r), 64'(grant), 64'(tbl[r].gnt));
      chk($sformatf("row%0d busy", r), 64'(busy), 64'(|tbl[r].gnt));
      chk($sformatf("row%0d bram_we", r), 64'(bram_we), 64'(tbl[r].bwe));
      chk($sformatf("row%0d bram_addr", r), 64'(bram_addr), 64'(tbl[r].baddr));
      chk($sformatf("row%0d bram_din", r), 64'(bram_din), 64'(exp_din(tbl[r].gnt)));
      chk($sformatf("row%0d timeout_err", r), 64'(timeout_err), 64'd0);
      step();
    end

    // Single requester: latency, read data, release and idle zeros
    do_reset();
    a[0] = 14'd5;
    d[0] = 32'h55;
    req  = 3'b001;
    #2 chk("s1 grant c0", 64'(grant), 64'd0);
    step();
    #2 chk("s1 grant c1", 64'(grant), 64'b001);
    chk("s1 bram_addr c1", 64'(bram_addr), 64'd5);
    chk("s1 bram_we c1", 64'(bram_we), 64'd0);
    step();
    req  = 3'b000;
    m_we = 3'b001;
    #2 chk("s1 m_dout c2", 64'(m_dout), 64'h1005);
    chk("s1 grant c2", 64'(grant), 64'b001);
    step();
    #2 chk("s1 grant release", 64'(grant), 64'd0);
    chk("s1 busy release", 64'(busy), 64'd0);
    chk("s1 bram_addr release", 64'(bram_addr), 64'd0);
    chk("s1 bram_we release", 64'(bram_we), 64'd0);
    chk("s1 bram_din release", 64'(bram_din), 64'd0);
    step();
    req = 3'b010;
    #2 chk("s1 grant idle", 64'(grant), 64'd0);
    chk("s1 bram_addr idle", 64'(bram_addr), 64'd0);
    chk("s1 bram_we idle", 64'(bram_we), 64'd0);
    step();
    #2 chk("s1 grant after idle", 64'(grant), 64'b010);
    req  = 3'b000;
    m_we = 3'b000;

    // Non-owner write must not reach the BRAM
    do_reset();
    a[0] = 14'd9;
    d[0] = 32'h55;
    a[1] = 14'd7;
    d[1] = 32'hDEADBEEF;
    m_we = 3'b010;
    req  = 3'b011;
    #2 chk("nw grant c0", 64'(grant), 64'd0);
    step();
    #2 chk("nw grant c1", 64'(grant), 64'b001);
    chk("nw bram_we c1", 64'(bram_we), 64'd0);
    chk("nw bram_addr c1", 64'(bram_addr), 64'd9);
    step();
    req = 3'b010;
    #2 chk("nw bram_we c2", 64'(bram_we), 64'd0);
    chk("nw bram_din c2", 64'(bram_din), 64'h55);
    step();
    m_we = 3'b000;
    #2 chk("nw grant release", 64'(grant), 64'd0);
    step();
    #2 chk("nw grant owner1", 64'(grant), 64'b010);
    chk("nw bram_addr owner1", 64'(bram_addr), 64'd7);
    chk("nw bram_we owner1", 64'(bram_we), 64'd0);
    step();
    #2 chk("nw readback loc7", 64'(m_dout), 64'h1007);
    req = 3'b000;

    // Asynchronous reset in the middle of a write session
    do_reset();
    a[0] = 14'd12;
    d[0] = 32'h77;
    m_we = 3'b001;
    req  = 3'b001;
    step();
    #2 chk("ar grant before", 64'(grant), 64'b001);
    chk("ar bram_we before", 64'(bram_we), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("ar grant async", 64'(grant), 64'd0);
    chk("ar bram_we async", 64'(bram_we), 64'd0);
    chk("ar busy async", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    m_we  = 3'b000;
    req   = 3'b110;
    #2 chk("ar grant c0", 64'(grant), 64'd0);
    step();
    #2 chk("ar first winner", 64'(grant), 64'b010);
    req = 3'b000;

`ifdef ARB_TIMEOUT_EN
    // Requester 2 holds forever: revoked after 16 cycles, masked until req drops
    do_reset();
    for (int c = 0; c < 26; c++) begin
      logic [N-1:0] eg;
      logic         ee;
      if (c < 5)       req = 3'b100;
      else if (c < 20) req = 3'b101;
      else if (c < 23) req = 3'b100;
      else if (c < 24) req = 3'b000;
      else             req = 3'b100;
      if (c >= 1 && c <= 16)       eg = 3'b100;
      else if (c >= 18 && c <= 20) eg = 3'b001;
      else if (c == 25)            eg = 3'b100;
      else                         eg = 3'b000;
      ee = (c == 17);
      #2;
      chk($sformatf("to c%0d grant", c), 64'(grant), 64'(eg));
      chk($sformatf("to c%0d timeout_err", c), 64'(timeout_err), 64'(ee));
      step();
    end
    req = 3'b000;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_bram_arbiter.md
# matrix_bram_arbiter

Shares the single port of the matrix-storage BRAM between several bus masters: matrix readers, the matrix writer and the compute engine. Each requester holds a level request for a whole access session and gets exclusive ownership of the port until it drops the request. Ownership rotates round-robin between sessions. The block sits between the bram_manager masters and the BRAM primitive.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- DATA_WIDTH, 32, BRAM word width
- ADDR_WIDTH, 14, BRAM address width
- HOLD_TIMEOUT, 4096, maximum session length in cycles (used only with ARB_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  level request per requester; held high for the whole session
- grant  out  NUM_REQ  one-hot (or zero) ownership, registered
- busy  out  1  OR of grant
- m_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i in slice i
- m_we  in  NUM_REQ  per-requester write enable
- m_din  in  NUM_REQ*DATA_WIDTH  per-requester write data
- m_dout  out  DATA_WIDTH  BRAM read data broadcast to all requesters
- bram_addr  out  ADDR_WIDTH  to BRAM
- bram_we  out  1  to BRAM
- bram_din  out  DATA_WIDTH  to BRAM
- bram_dout  in  DATA_WIDTH  from BRAM, 1-cycle read latency
- timeout_err  out  1  one-cycle pulse when a session is revoked

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: when any req is high, pick a winner with round-robin. Register grant to the winner and go to GRANT.
- GRANT: the owner's m_addr, m_we and m_din pass combinationally to the bram_* outputs. When req[owner] goes low, clear grant and go to RELEASE.
- RELEASE: one turnaround cycle with bram_we=0.
  - Any eligible req high: grant the new winner and go to GRANT.
  - Otherwise: go to IDLE.
- Round-robin: the search starts at index last_owner+1 mod NUM_REQ. last_owner updates on every grant. After reset, search starts at index 0.
- No grant active: bram_addr=0, bram_we=0, bram_din=0.
- m_dout = bram_dout at all times, ungated. A requester treats data as valid only on the cycle after it presented an address while granted.
- Non-owner m_we is ignored. Non-owner req stays pending with no limit; there is no queue beyond the level req.
- Owner req high again in RELEASE: it competes normally. Round-robin puts it last.

## Timing
- Reset values: grant=0, busy=0, bram_addr=0, bram_we=0, bram_din=0, timeout_err=0. State=IDLE, last_owner=NUM_REQ-1.
- Grant latency: req high sampled at posedge N in IDLE gives grant high after posedge N (visible in cycle N+1).
- First owner access is in the cycle grant is high; its read data appears one cycle later.
- Release: req low at posedge N clears grant after N. That cycle is RELEASE. The next grant is visible at N+2.
- Simultaneous requests in the same cycle: round-robin order decides. The grant is never split.
- Reset mid-session: grant and bram_we drop asynchronously. An in-flight write is lost; the requester restarts.
- grant never changes while the owner's req is high, unless a timeout occurs.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in GRANT, cleared on each new grant.
  - On reaching HOLD_TIMEOUT-1, the block clears grant, pulses timeout_err for one cycle and goes to RELEASE.
  - The revoked requester is masked from arbitration until its req has been low for at least one cycle.
- ARB_TIMEOUT_EN undefined: no counter, no mask; timeout_err is tied to 0 and sessions are unbounded.

## Structure
- Shared package matrix_bram_pkg holds:
  - arb_state_t enum
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with matrix_reader and the writer
- Sub-module rr_picker, purely combinational.
  - Inputs: req vector (after mask), last_owner.
  - Outputs: one-hot winner and its index.

## Test plan
- Reset, then req=3'b001 at cycle 2: grant=001 visible at cycle 3. m_addr[0]=5 gives bram_addr=5; BRAM word 5 appears on m_dout at cycle 4.
- req=3'b111 held, each owner keeps its session for 4 cycles then drops req for 2 cycles:
  - grant order 001, 010, 100, 001
  - one RELEASE cycle between sessions, with bram_we=0
- Non-owner m_we=1 with m_addr=7 while requester 0 owns the port: BRAM location 7 is unchanged (checked by read-back).
- Owner drops req at posedge 10 with no other requesters: grant=0 at 11 (RELEASE), state IDLE at 12, bram_* outputs all zero.
- Assert rst_n=0 mid-write: grant and bram_we go to 0 without waiting for a clock edge. After release of reset, req=3'b110 grants requester 1 first.
- ARB_TIMEOUT_EN with HOLD_TIMEOUT=16, requester 2 holds req indefinitely:
  - grant revoked after 16 cycles; timeout_err pulses once
  - requester 2 gets no grant until its req toggles low
  - requester 0 is served in the meantime
